// File: rtl/shift_right_pipelined.sv
`timescale 1ns/1ps
// shift_right_pipelined
//   Five-stage pipelined right shifter: logical, arithmetic and (optionally)
//   rotate right of a 32-bit operand by 0-31. Stage k conditionally shifts by
//   16>>k, controlled by shift-amount bit (4-k). Valid/ready on both sides.
//
//   Build option: define SHIFT_ROTATE_EN to make ctrl_mode=10 a rotate right;
//   otherwise mode 10 (like the reserved mode 11) is a logical shift.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   in_valid       upstream presents an operation
//   in_ready       operation accepted this cycle (combinational from out_ready)
//   data_operandA  value to shift
//   ctrl_shiftamt  shift amount 0-31
//   ctrl_mode      00 logical, 01 arithmetic, 10 rotate, 11 reserved (logical)
//   out_valid      data_result holds a completed result
//   out_ready      downstream consumes the result this cycle
//   data_result    shifted value
//   busy           any stage holds a valid operation
module shift_right_pipelined #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  data_operandA,
  input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
  input  logic [1:0]             ctrl_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  data_result,
  output logic                   busy
);

  localparam int unsigned STAGES = SHAMT_WIDTH;

  // Stage registers. The last stage only needs data and valid: all shifting
  // is done on the way into a register, so control is not kept past it.
  logic [STAGES-1:0]      valid_q;
  logic [DATA_WIDTH-1:0]  data_q  [STAGES];
  logic [SHAMT_WIDTH-1:0] shamt_q [STAGES-1];
  logic                   fill_q  [STAGES-1];
`ifdef SHIFT_ROTATE_EN
  logic                   rot_q   [STAGES-1];
`endif

  // Per-stage inputs (from the ports for stage 0, else from the previous
  // stage register) and the shifted value each register would load.
  logic [DATA_WIDTH-1:0]  in_data  [STAGES];
  logic [SHAMT_WIDTH-1:0] in_shamt [STAGES];
  logic                   in_fill  [STAGES];
  logic                   in_rot   [STAGES];
  logic [DATA_WIDTH-1:0]  nxt_data [STAGES];

  // go[k]: stage k hands its content on this cycle.
  // ld[k]: register k loads new content this cycle.
  logic [STAGES-1:0]      go;
  logic [STAGES-1:0]      ld;

  // Right shift by amt, taking fill bits either from the fill value or,
  // for a rotate, from the operand itself.
  function automatic logic [DATA_WIDTH-1:0] shift_stage(
    input logic [DATA_WIDTH-1:0] d,
    input int unsigned           amt,
    input logic                  fill,
    input logic                  rot
  );
    logic [2*DATA_WIDTH-1:0] ext;
    ext = {(rot ? d : {DATA_WIDTH{fill}}), d};
    return ext[amt +: DATA_WIDTH];
  endfunction

  always_comb begin
    // Fill bit is decided once at the input: operand MSB for arithmetic,
    // zero otherwise; it then travels with the operation.
    in_data[0]  = data_operandA;
    in_shamt[0] = ctrl_shiftamt;
    in_fill[0]  = (ctrl_mode == 2'b01) & data_operandA[DATA_WIDTH-1];
`ifdef SHIFT_ROTATE_EN
    in_rot[0]   = (ctrl_mode == 2'b10);
`else
    in_rot[0]   = 1'b0;
`endif
    for (int unsigned k = 1; k < STAGES; k++) begin
      in_data[k]  = data_q[k-1];
      in_shamt[k] = shamt_q[k-1];
      in_fill[k]  = fill_q[k-1];
`ifdef SHIFT_ROTATE_EN
      in_rot[k]   = rot_q[k-1];
`else
      in_rot[k]   = 1'b0;
`endif
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (in_shamt[k][SHAMT_WIDTH-1-k])
        nxt_data[k] = shift_stage(in_data[k], DATA_WIDTH >> (k + 1),
                                  in_fill[k], in_rot[k]);
      else
        nxt_data[k] = in_data[k];
    end
  end

  // Backpressure chain, evaluated from the output back to the input.
  always_comb begin
    go = '0;
    ld = '0;
    go[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int unsigned i = 0; i < STAGES - 1; i++) begin
      go[STAGES-2-i] = !valid_q[STAGES-1-i] || go[STAGES-1-i];
    end
    ld[0] = !valid_q[0] || go[0];
    for (int unsigned k = 1; k < STAGES; k++) begin
      ld[k] = go[k-1];
    end
  end

  assign in_ready    = ld[0];
  assign out_valid   = valid_q[STAGES-1];
  assign data_result = data_q[STAGES-1];
  assign busy        = |valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
      for (int unsigned k = 0; k < STAGES - 1; k++) begin
        shamt_q[k] <= '0;
        fill_q[k]  <= 1'b0;
`ifdef SHIFT_ROTATE_EN
        rot_q[k]   <= 1'b0;
`endif
      end
    end else begin
      if (ld[0]) begin
        valid_q[0] <= in_valid;
        data_q[0]  <= nxt_data[0];
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= nxt_data[k];
        end
      end
      for (int unsigned k = 0; k < STAGES - 1; k++) begin
        if (ld[k]) begin
          shamt_q[k] <= in_shamt[k];
          fill_q[k]  <= in_fill[k];
`ifdef SHIFT_ROTATE_EN
          rot_q[k]   <= in_rot[k];
`endif
        end
      end
    end
  end

endmodule
